// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings and baud timing
// for the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        BUF_IDLE,
        BUF_LOAD,
        BUF_SEND,
        BUF_DONE
    } buff_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART byte serializer: start bit, N_BITS data bits LSB first,
// stop bit, behind a tdata/tvalid/tready byte input.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int N_BITS    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BITS-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic              tx
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CW  = cnt_width(CPB);
    localparam int BW  = cnt_width(N_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [N_BITS-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              bit_end;

    assign bit_end  = (cnt_q == CNT_LAST);
    assign s_tready = (state_q == TX_IDLE);
    assign tx       = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        unique case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (s_tvalid) begin
                    shift_d = s_tdata;
                    tx_d    = 1'b0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        tx_d  = shift_d[0];
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/uart_tx_buff.sv
// Message-level UART transmitter: captures up to WORD_SIZE bytes
// and feeds them, lowest index first, to the byte serializer.
module uart_tx_buff
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int N_BITS    = 8,
    parameter int WORD_SIZE = 79
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_BITS*WORD_SIZE-1:0]   uart_word_tdata,
    input  logic [$clog2(WORD_SIZE+1)-1:0] uart_word_tlen,
    input  logic                          uart_word_tvalid,
    output logic                          uart_word_tready,
    output logic                          tx_data,
    output logic                          uart_word_done
);

    localparam int LW = $clog2(WORD_SIZE + 1);
    localparam int DW = N_BITS * WORD_SIZE;
    localparam logic [LW-1:0] LEN_MAX = LW'(WORD_SIZE);

    buff_state_e       state_q, state_d;
    logic [DW-1:0]     data_q, data_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     idx_q, idx_d;
    logic              tready_q, tready_d;
    logic              done_q, done_d;
    logic              bvalid_q, bvalid_d;
    logic [N_BITS-1:0] byte_tdata;
    logic              byte_tready;
    logic [LW-1:0]     len_in;
    logic              accept;
    logic              more;

    assign len_in     = (uart_word_tlen > LEN_MAX) ? LEN_MAX : uart_word_tlen;
    assign accept     = uart_word_tvalid && tready_q;
    assign more       = (idx_q + 1'b1) < len_q;
    assign byte_tdata = data_q[int'(idx_q) * N_BITS +: N_BITS];

    assign uart_word_tready = tready_q;
    assign uart_word_done   = done_q;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        len_d    = len_q;
        idx_d    = idx_q;
        bvalid_d = bvalid_q;
        tready_d = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            BUF_IDLE: begin
                tready_d = 1'b1;
                if (accept) begin
                    data_d   = uart_word_tdata;
                    len_d    = len_in;
                    idx_d    = '0;
                    bvalid_d = (len_in != '0);
                    tready_d = 1'b0;
                    state_d  = BUF_LOAD;
                end
            end
            BUF_LOAD: begin
                // An empty message skips straight to the done pulse
                if (len_q == '0) begin
                    done_d  = 1'b1;
                    state_d = BUF_DONE;
                end else if (byte_tready) begin
                    bvalid_d = 1'b0;
                    state_d  = BUF_SEND;
                end
            end
            BUF_SEND: begin
                if (byte_tready) begin
                    if (more) begin
                        idx_d    = idx_q + 1'b1;
                        bvalid_d = 1'b1;
                        state_d  = BUF_LOAD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = BUF_DONE;
                    end
                end
            end
            BUF_DONE: begin
                tready_d = 1'b1;
                state_d  = BUF_IDLE;
            end
            default: state_d = BUF_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= BUF_IDLE;
            data_q   <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            tready_q <= 1'b0;
            done_q   <= 1'b0;
            bvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            tready_q <= tready_d;
            done_q   <= done_d;
            bvalid_q <= bvalid_d;
        end
    end

    uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE),
        .N_BITS   (N_BITS)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .s_tdata (byte_tdata),
        .s_tvalid(bvalid_q),
        .s_tready(byte_tready),
        .tx      (tx_data)
    );

endmodule

// File: tb/tb_uart_tx_buff.sv
// Scoreboard bench for uart_tx_buff: a line decoder and a done
// monitor compare against bytes queued when each message is accepted.
module tb_uart_tx_buff;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int NB       = 8;
    localparam int WS       = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] word_tdata = '0;
    logic [2:0]  word_tlen = '0;
    logic        word_tvalid = 1'b0;
    logic        word_tready;
    logic        tx_data;
    logic        word_done;

    always #5 clk = ~clk;

    uart_tx_buff #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD),
        .N_BITS   (NB),
        .WORD_SIZE(WS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .uart_word_tdata (word_tdata),
        .uart_word_tlen  (word_tlen),
        .uart_word_tvalid(word_tvalid),
        .uart_word_tready(word_tready),
        .tx_data         (tx_data),
        .uart_word_done  (word_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    int         dn_q[$];
    time        acc_time = 0;
    time        last_det = 0;
    time        last_done_t = 0;
    bit         first_byte = 1'b0;
    bit         dec_busy = 1'b0;
    int         dec_cnt = 0;
    logic [7:0] dec_byte = '0;
    logic [7:0] dec_exp = '0;
    bit         dec_start_ok = 1'b0;
    bit         prev_done = 1'b0;

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // line decoder: samples mid-bit, 10 clocks per bit
    always @(negedge clk) begin
        if (!rst) begin
            dec_busy = 1'b0;
            exp_q.delete();
            dn_q.delete();
        end else if (!dec_busy) begin
            if (tx_data === 1'b0) begin
                dec_busy     = 1'b1;
                dec_cnt      = 0;
                dec_byte     = '0;
                dec_start_ok = 1'b1;
                if (first_byte) begin
                    chk(($time - acc_time) <= 25, "start_latency",
                        32'($time - acc_time), 32'd25);
                    first_byte = 1'b0;
                end else begin
                    chk(($time - last_det) >= 1000 && ($time - last_det) <= 1020,
                        "byte_gap", 32'($time - last_det), 32'd1020);
                end
                last_det = $time;
            end
        end else begin
            dec_cnt++;
            if (dec_cnt == 5) begin
                if (tx_data !== 1'b0) dec_start_ok = 1'b0;
            end else if (dec_cnt >= 15 && dec_cnt <= 85 && (dec_cnt - 5) % 10 == 0) begin
                dec_byte[(dec_cnt - 15) / 10] = tx_data;
            end else if (dec_cnt == 95) begin
                dec_busy = 1'b0;
                chk(dec_start_ok && tx_data === 1'b1, "framing",
                    {30'd0, dec_start_ok, tx_data}, 32'd3);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_byte", {24'd0, dec_byte}, 32'd0);
                end else begin
                    dec_exp = exp_q.pop_front();
                    chk(dec_byte == dec_exp, "byte_value", {24'd0, dec_byte}, {24'd0, dec_exp});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (word_done) begin
                chk(!prev_done, "done_width", 32'd2, 32'd1);
                last_done_t = $time;
                if (dn_q.size() == 0) begin
                    chk(1'b0, "unexpected_done", 32'd1, 32'd0);
                end else begin
                    automatic int l = dn_q.pop_front();
                    chk(exp_q.size() == 0 && !dec_busy, "done_order",
                        32'(exp_q.size()), 32'd0);
                    if (l == 0)
                        chk(($time - acc_time) <= 25, "done_empty_latency",
                            32'($time - acc_time), 32'd15);
                    else
                        chk(($time - last_det) >= 1000 && ($time - last_det) <= 1030,
                            "done_latency", 32'($time - last_det), 32'd1010);
                end
            end
        end
        prev_done = word_done;
    end

    task automatic send_msg(input logic [31:0] d, input logic [2:0] l);
        bit got = 1'b0;
        bit held;
        int n;
        @(negedge clk);
        word_tdata  = d;
        word_tlen   = l;
        word_tvalid = 1'b1;
        held = (word_tready !== 1'b1);
        for (int w = 0; w < 3000 && !got; w++) begin
            if (word_tready === 1'b1) begin
                @(posedge clk);
                got = 1'b1;
                acc_time = $time;
                first_byte = 1'b1;
                n = (l > 3'(WS)) ? WS : int'(l);
                for (int k = 0; k < n; k++) exp_q.push_back(d[k*8 +: 8]);
                dn_q.push_back(n);
                if (held)
                    chk((acc_time - last_done_t) == 15, "pending_accept",
                        32'(acc_time - last_done_t), 32'd15);
            end else begin
                @(negedge clk);
            end
        end
        if (!got) chk(1'b0, "accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        word_tvalid = 1'b0;
        word_tdata  = $urandom;
        word_tlen   = 3'($urandom);
    endtask

    task automatic drain();
        for (int w = 0; w < 3000 && dn_q.size() != 0; w++) @(negedge clk);
        chk(dn_q.size() == 0, "drain_done", 32'(dn_q.size()), 32'd0);
        chk(exp_q.size() == 0, "drain_bytes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic idle_check(input int cycles, input string name);
        bit ok = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx_data !== 1'b1 || word_tready !== 1'b1 || word_done !== 1'b0) ok = 1'b0;
        end
        chk(ok, name, {29'd0, tx_data, word_tready, word_done}, 32'h6);
    endtask

    initial begin
        #12;
        chk(tx_data === 1'b1, "reset_tx", {31'd0, tx_data}, 32'd1);
        chk(word_tready === 1'b0, "reset_tready", {31'd0, word_tready}, 32'd0);
        chk(word_done === 1'b0, "reset_done", {31'd0, word_done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk(word_tready === 1'b1, "release_tready", {31'd0, word_tready}, 32'd1);
        idle_check(50, "idle_after_reset");

        send_msg(32'h4433_2211, 3'd4);
        send_msg(32'h4433_2211, 3'd2);
        send_msg(32'h4433_2211, 3'd0);
        send_msg(32'hA5C3_0FF0, 3'd7);
        drain();

        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3) * 7) @(negedge clk);
            send_msg($urandom, 3'($urandom_range(0, 7)));
        end
        drain();

        send_msg(32'h4433_2211, 3'd4);
        for (int w = 0; w < 3000 && exp_q.size() > 3; w++) @(negedge clk);
        chk(exp_q.size() == 3, "first_byte_seen", 32'(exp_q.size()), 32'd3);
        repeat (30) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk(tx_data === 1'b1, "abort_tx", {31'd0, tx_data}, 32'd1);
        chk(word_tready === 1'b0, "abort_tready", {31'd0, word_tready}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk(word_tready === 1'b1, "abort_release_tready", {31'd0, word_tready}, 32'd1);
        idle_check(300, "idle_after_abort");

        send_msg(32'h4433_2211, 3'd4);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_buff.md
UART_TX_BUFF -- requirements
Module: uart_tx_buff

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25_000_000, the clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, the serial bit rate.
REQ-003 SHALL have parameter N_BITS, default 8, the data bits per UART frame.
REQ-004 SHALL have parameter WORD_SIZE, default 79, the maximum number of bytes per message (NMEA sentence length).
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port uart_word_tdata, input, N_BITS*WORD_SIZE bits: the message; byte k occupies bits [k*N_BITS +: N_BITS].
REQ-008 SHALL have port uart_word_tlen, input, $clog2(WORD_SIZE+1) bits: the number of bytes to send.
REQ-009 SHALL have port uart_word_tvalid, input, 1 bit: the message is valid.
REQ-010 SHALL have port uart_word_tready, output, 1 bit: the block can accept a message.
REQ-011 SHALL have port tx_data, output, 1 bit: the serial line to the outside world.
REQ-012 SHALL have port uart_word_done, output, 1 bit: one-cycle pulse after the last stop bit.

Function
REQ-013 SHALL use CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer truncation); every bit lasts exactly CLKS_PER_BIT cycles.
REQ-014 SHALL send each frame as 1 start bit (0), then N_BITS data bits LSB first, then 1 stop bit (1); the line idles at 1.
REQ-015 SHALL accept a message on the clk edge where tvalid && tready, capturing tdata and tlen into internal registers; later input changes SHALL have no effect.
REQ-016 SHALL assert tready only in the IDLE state.
REQ-017 SHALL implement the states IDLE, LOAD, SEND and DONE.
REQ-018 SHALL make these transitions: IDLE->LOAD on accept; LOAD->SEND by handing the byte at index idx to the serializer; SEND->LOAD when a byte finishes and idx+1 < len; SEND->DONE when the last byte finishes; DONE->IDLE after one cycle.
REQ-019 SHALL send bytes in ascending index order, byte 0 first.
REQ-020 SHALL drive the start bit of byte 0 on tx_data at most 2 cycles after the accept edge.
REQ-021 SHALL send consecutive bytes with at most 2 idle cycles between a stop bit and the next start bit.
REQ-022 SHALL assert uart_word_done for exactly one cycle, in the DONE state.
REQ-023 SHALL, for tlen = 0: accept the message, send nothing, keep tx_data at 1 and pulse done 2 cycles after accept.
REQ-024 SHALL clamp tlen > WORD_SIZE to WORD_SIZE.
REQ-025 SHALL hold tready low while tvalid is held during transmission; the pending message SHALL be accepted on the first IDLE cycle.
REQ-026 SHALL register tx_data, so that it is glitch-free.

Reset
REQ-027 SHALL, while rst = 0, immediately set tx_data=1, tready=0, uart_word_done=0, state=IDLE, idx=0 and the bit/baud counters to 0.
REQ-028 SHALL abort any frame in progress when reset is asserted mid-frame; no partial byte SHALL resume after release.
REQ-029 SHALL make tready high on the first clk edge after rst is released.

Structure
REQ-030 SHALL place the state encoding and the CLKS_PER_BIT derivation in the shared uart package, alongside the receive side.
REQ-031 SHALL use a single sub-module, uart_tx, with parameters CLK_FREQ, BAUD_RATE and N_BITS.
REQ-032 SHALL give uart_tx an AXI-stream-style byte input (tdata/tvalid/tready) and the serial output; uart_tx SHALL own the baud counter and bit shifter.
REQ-033 SHALL keep message buffering, indexing and the state machine in uart_tx_buff.

Verification (all scenarios: CLK_FREQ=1_000_000, BAUD_RATE=100_000, i.e. 10 clks/bit, N_BITS=8, WORD_SIZE=4)
REQ-034 SHALL cover: reset, then idle 50 cycles -> tx_data=1 throughout, tready=1, done=0.
REQ-035 SHALL cover: tdata=0x44_33_22_11, tlen=4 -> line decodes to 0x11, 0x22, 0x33, 0x44, each 100 cycles; done pulses once after the final stop bit.
REQ-036 SHALL cover: tlen=2 with the same data -> only 0x11 and 0x22 are sent; done pulses; line returns to 1.
REQ-037 SHALL cover: tlen=0 -> no start bit appears; done pulses 2 cycles after accept.
REQ-038 SHALL cover: tlen=7 -> exactly 4 bytes are sent (clamped to WORD_SIZE).
REQ-039 SHALL cover: rst=0 asserted mid-bit in byte 1 -> tx_data=1 within the same cycle; after release, tready=1 and no residual bits are sent.
